// File: rtl/alarm_zone_controller_pkg.sv
// Shared state encoding and state-group decodes for the alarm zone controller,
// also used by LED/debug decode logic elsewhere on the board.
package alarm_zone_controller_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_DISARMED    = 3'd0,
        ST_EXIT_DELAY  = 3'd1,
        ST_ARMED       = 3'd2,
        ST_ENTRY_DELAY = 3'd3,
        ST_ALARM       = 3'd4,
        ST_SILENCED    = 3'd5,
        ST_PANIC       = 3'd6
    } state_e;

    function automatic logic is_armed_group(state_e s);
        return s inside {ST_EXIT_DELAY, ST_ARMED, ST_ENTRY_DELAY, ST_ALARM, ST_SILENCED};
    endfunction

    function automatic logic is_latch_group(state_e s);
        return s inside {ST_ARMED, ST_ENTRY_DELAY, ST_ALARM, ST_SILENCED};
    endfunction

    function automatic logic is_flash_group(state_e s);
        return s inside {ST_ALARM, ST_SILENCED, ST_PANIC};
    endfunction

    function automatic logic is_siren_group(state_e s);
        return s inside {ST_ALARM, ST_PANIC};
    endfunction

endpackage

// File: rtl/alarm_zone_controller_tick_downcounter.sv
// Loadable down-counter that steps only on the timebase tick and saturates at zero.
// A load in the same cycle as a tick takes precedence.
module tick_downcounter #(
    parameter int CNT_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             tick,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    // NOTE: sequential state is written with non-blocking assignments only, so every
    // flop samples pre-edge values regardless of the order the blocks are evaluated in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (tick && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/alarm_zone_controller.sv
// N-zone intruder alarm controller: exit/entry delays, per-zone bypass, siren timeout,
// panic, and a flashing strobe, all timed from an external 1-cycle tick enable.
module alarm_zone_controller
    import alarm_zone_controller_pkg::*;
#(
    parameter int                   NUM_ZONES   = 3,
    parameter int                   CNT_W       = 12,
    parameter int                   EXIT_TICKS  = 200,
    parameter int                   ENTRY_TICKS = 100,
    parameter int                   SIREN_TICKS = 2400,
    parameter int                   STROBE_HALF = 4,
    parameter logic [NUM_ZONES-1:0] ENTRY_MASK  = NUM_ZONES'(1)
) (
    input  logic                 iCLK,
    input  logic                 iRST_N,
    input  logic                 iTICK,
    input  logic                 iARM,
    input  logic                 iPANIC,
    input  logic [NUM_ZONES-1:0] iZONE,
    input  logic [NUM_ZONES-1:0] iBYPASS,
    output logic [STATE_W-1:0]   oSTATE,
    output logic                 oSIREN,
    output logic                 oSTROBE,
    output logic [NUM_ZONES-1:0] oZONE_LATCHED,
    output logic                 oARMED,
    output logic                 oDISARMED,
    output logic                 oARM_REJECT
);

    localparam longint CNT_LIMIT = longint'(1) << CNT_W;
    localparam logic [CNT_W-1:0] EXIT_LOAD  = CNT_W'(EXIT_TICKS - 1);
    localparam logic [CNT_W-1:0] ENTRY_LOAD = CNT_W'(ENTRY_TICKS - 1);
    localparam logic [CNT_W-1:0] SIREN_LOAD = CNT_W'(SIREN_TICKS - 1);
    localparam int               STB_W      = (STROBE_HALF > 1) ? $clog2(STROBE_HALF) : 1;
    localparam logic [STB_W-1:0] STB_LAST   = STB_W'(STROBE_HALF - 1);

    if (NUM_ZONES < 1 || NUM_ZONES > 16) begin : g_bad_zones
        $error("NUM_ZONES must be in 1..16");
    end
    if (EXIT_TICKS < 1 || EXIT_TICKS >= CNT_LIMIT) begin : g_bad_exit
        $error("EXIT_TICKS out of range for CNT_W");
    end
    if (ENTRY_TICKS < 1 || ENTRY_TICKS >= CNT_LIMIT) begin : g_bad_entry
        $error("ENTRY_TICKS out of range for CNT_W");
    end
    if (SIREN_TICKS < 1 || SIREN_TICKS >= CNT_LIMIT) begin : g_bad_siren
        $error("SIREN_TICKS out of range for CNT_W");
    end
    if (STROBE_HALF < 1) begin : g_bad_strobe
        $error("STROBE_HALF must be >= 1");
    end

    state_e               state_q, state_d;
    logic [NUM_ZONES-1:0] active, latched_q;
    logic                 instant_hit, entry_hit, new_hit;
    logic                 cnt_load, cnt_zero, timer_done;
    logic [CNT_W-1:0]     cnt_load_val;
    logic                 reject_d, clear_latch;
    logic [STB_W-1:0]     stb_cnt_q, stb_cnt_d;
    logic                 phase_q, phase_d, flash_entry;
    logic                 siren_q, strobe_q, armed_q, disarmed_q, reject_q;

    assign active      = iZONE & ~iBYPASS;
    assign instant_hit = |(active & ~ENTRY_MASK);
    assign entry_hit   = |(active & ENTRY_MASK);
    assign new_hit     = |(active & ~latched_q);
    assign timer_done  = iTICK & cnt_zero;

    tick_downcounter #(.CNT_W(CNT_W)) u_delay_cnt (
        .clk      (iCLK),
        .rst_n    (iRST_N),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .tick     (iTICK),
        .zero     (cnt_zero)
    );

    // NOTE: every signal driven here gets a default first, so no path can leave one
    // unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        reject_d     = 1'b0;
        clear_latch  = 1'b0;

        if (iPANIC && state_q != ST_PANIC) begin
            state_d = ST_PANIC;
        end else if (iARM) begin
            if (state_q == ST_DISARMED) begin
                if (active == '0) begin
                    state_d      = ST_EXIT_DELAY;
                    cnt_load     = 1'b1;
                    cnt_load_val = EXIT_LOAD;
                    clear_latch  = 1'b1;
                end else begin
                    reject_d = 1'b1;
                end
            end else begin
                state_d = ST_DISARMED;
            end
        end else begin
            unique case (state_q)
                ST_EXIT_DELAY: if (timer_done) state_d = ST_ARMED;
                ST_ARMED: begin
                    // A non-entry zone alarms at once even if an entry zone opened too.
                    if (instant_hit) begin
                        state_d      = ST_ALARM;
                        cnt_load     = 1'b1;
                        cnt_load_val = SIREN_LOAD;
                    end else if (entry_hit) begin
                        state_d      = ST_ENTRY_DELAY;
                        cnt_load     = 1'b1;
                        cnt_load_val = ENTRY_LOAD;
                    end
                end
                ST_ENTRY_DELAY: begin
                    if (timer_done || instant_hit) begin
                        state_d      = ST_ALARM;
                        cnt_load     = 1'b1;
                        cnt_load_val = SIREN_LOAD;
                    end
                end
                ST_ALARM: if (timer_done) state_d = ST_SILENCED;
                ST_SILENCED: begin
                    if (new_hit) begin
                        state_d      = ST_ALARM;
                        cnt_load     = 1'b1;
                        cnt_load_val = SIREN_LOAD;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    // Restarting the strobe on alarm/panic entry makes the first flash immediate.
    assign flash_entry = is_siren_group(state_d) && (state_d != state_q);

    always_comb begin
        stb_cnt_d = stb_cnt_q;
        phase_d   = phase_q;
        if (flash_entry) begin
            stb_cnt_d = '0;
            phase_d   = 1'b1;
        end else if (iTICK) begin
            if (stb_cnt_q == STB_LAST) begin
                stb_cnt_d = '0;
                phase_d   = ~phase_q;
            end else begin
                stb_cnt_d = stb_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q    <= ST_DISARMED;
            latched_q  <= '0;
            stb_cnt_q  <= '0;
            phase_q    <= 1'b0;
            siren_q    <= 1'b0;
            strobe_q   <= 1'b0;
            armed_q    <= 1'b0;
            disarmed_q <= 1'b1;
            reject_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            stb_cnt_q  <= stb_cnt_d;
            phase_q    <= phase_d;
            siren_q    <= is_siren_group(state_d);
            strobe_q   <= phase_d & is_flash_group(state_d);
            armed_q    <= is_armed_group(state_d);
            disarmed_q <= (state_d == ST_DISARMED);
            reject_q   <= reject_d;
            if (clear_latch) begin
                latched_q <= '0;
            end else if (is_latch_group(state_q)) begin
                latched_q <= latched_q | active;
            end
        end
    end

    assign oSTATE        = state_q;
    assign oSIREN        = siren_q;
    assign oSTROBE       = strobe_q;
    assign oZONE_LATCHED = latched_q;
    assign oARMED        = armed_q;
    assign oDISARMED     = disarmed_q;
    assign oARM_REJECT   = reject_q;

endmodule
